// File: rtl/sa_autosa_rubik_pkg.sv
// Shared types and helpers for the Rubik read-response lane splitter/packer.
package sa_autosa_rubik_pkg;

  localparam int LANE_W_DFLT = 256;
  localparam int LANE_ENT_W  = LANE_W_DFLT + 1;

  typedef enum logic [1:0] {
    BYP   = 2'd0,
    PACK  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic int popcount(input logic [31:0] m);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(m[i]);
    return c;
  endfunction

  function automatic int rot_idx(input int base, input int off, input int lanes);
    return (base + off) % lanes;
  endfunction

endpackage

// File: rtl/sa_autosa_rubik_lane_fifo.sv
// Single-lane FIFO with registered full/empty; ready depends only on the
// occupancy at the start of the cycle, so a full FIFO never passes through.
module sa_autosa_rubik_lane_fifo #(
  parameter int WIDTH = 257,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pwrbus_ram_pd,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_pd,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_pd
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             push, pop;
  logic             unused_pd;

  // Power-down hint is not used by the flop-based storage.
  assign unused_pd = ^pwrbus_ram_pd;

  assign in_rdy  = ~full_q;
  assign out_vld = ~empty_q;
  assign push    = in_vld & ~full_q;
  assign pop     = out_rdy & ~empty_q;
  assign out_pd  = mem_q[rd_ptr_q];
  assign cnt_d   = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (AW+1)'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_pd;
  end

endmodule

// File: rtl/sa_autosa_rubik_dr2drc_pack.sv
// Splits masked read responses into per-lane FIFOs (bypass keeps alignment,
// pack compacts valid lanes via a rotor) and joins the lane heads into beats.
module sa_autosa_rubik_dr2drc_pack
  import sa_autosa_rubik_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int LANE_W = LANE_W_DFLT,
  parameter int DEPTH  = 8
) (
  input  logic                        autosa_core_clk,
  input  logic                        autosa_core_rstn,
  input  logic [31:0]                 pwrbus_ram_pd,
  input  logic                        cfg_pack_en,
  input  logic                        cfg_flush,
  output logic                        flush_done,
  input  logic                        rd_rsp_vld,
  output logic                        rd_rsp_rdy,
  input  logic [LANES*(LANE_W+1)-1:0] rd_rsp_pd,
  output logic                        data_fifo_vld,
  input  logic                        data_fifo_rdy,
  output logic [LANES*LANE_W-1:0]     data_fifo_pd,
  output logic [LANES-1:0]            data_fifo_mask,
  output logic                        rd_cdt_lat_fifo_pop
);
  localparam int ENT_W = LANE_W + 1;
  localparam int RW    = $clog2(LANES);

  state_e               state_q, state_d;
  logic [RW-1:0]        rotor_q, rotor_d;
  logic                 rdy_en_q;
  logic                 flush_done_q, flush_done_d;
  logic [LANES-1:0]     mask_in;
  logic [LANES*LANE_W-1:0] data_in;
  logic [LANES-1:0]     push, fifo_rdy, fifo_vld;
  logic [ENT_W-1:0]     push_ent [LANES];
  logic [ENT_W-1:0]     head     [LANES];
  logic                 acc, pop, flush_ok;
  int                   k;

  assign mask_in = rd_rsp_pd[LANES*(LANE_W+1)-1 -: LANES];
  assign data_in = rd_rsp_pd[LANES*LANE_W-1:0];

  // Ready is built only from registered state, never from data_fifo_rdy.
  assign rd_rsp_rdy          = rdy_en_q & (state_q != FLUSH) & (&fifo_rdy);
  assign acc                 = rd_rsp_vld & rd_rsp_rdy;
  assign data_fifo_vld       = &fifo_vld;
  assign pop                 = data_fifo_vld & data_fifo_rdy;
  assign rd_cdt_lat_fifo_pop = pop;
  assign flush_done          = flush_done_q;

  always_comb begin
    flush_ok = 1'b1;
    for (int f = 0; f < LANES; f++) begin
      if (f >= int'(rotor_q) && !fifo_rdy[f]) flush_ok = 1'b0;
    end
  end

  always_comb begin
    logic [RW-1:0] dest;
    int            c;
    push         = '0;
    for (int f = 0; f < LANES; f++) push_ent[f] = '0;
    dest         = '0;
    c            = 0;
    k            = popcount(32'(mask_in));
    rotor_d      = rotor_q;
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      BYP: begin
        if (acc) begin
          for (int f = 0; f < LANES; f++) begin
            push[f]     = 1'b1;
            push_ent[f] = mask_in[f] ? {1'b1, data_in[f*LANE_W +: LANE_W]} : '0;
          end
        end
        if (cfg_pack_en) state_d = PACK;
      end
      PACK: begin
        if (acc) begin
          for (int i = 0; i < LANES; i++) begin
            if (mask_in[i]) begin
              dest           = RW'(rot_idx(int'(rotor_q), c, LANES));
              push[dest]     = 1'b1;
              push_ent[dest] = {1'b1, data_in[i*LANE_W +: LANE_W]};
              c++;
            end
          end
          rotor_d = RW'(rot_idx(int'(rotor_q), k, LANES));
        end
        // Decisions look at the post-accept rotor so a partial beat is never stranded.
        if (cfg_flush) begin
          if (rotor_d != '0) state_d = FLUSH;
          else               flush_done_d = 1'b1;
        end else if (!cfg_pack_en && rotor_d == '0) begin
          state_d = BYP;
        end
      end
      FLUSH: begin
        if (flush_ok) begin
          for (int f = 0; f < LANES; f++) begin
            if (rotor_q != '0 && f >= int'(rotor_q)) push[f] = 1'b1;
          end
          rotor_d      = '0;
          flush_done_d = 1'b1;
          state_d      = cfg_pack_en ? PACK : BYP;
        end
      end
      default: state_d = BYP;
    endcase
  end

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      state_q      <= BYP;
      rotor_q      <= '0;
      rdy_en_q     <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rotor_q      <= rotor_d;
      rdy_en_q     <= 1'b1;
      flush_done_q <= flush_done_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sa_autosa_rubik_lane_fifo #(
      .WIDTH(ENT_W),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk          (autosa_core_clk),
      .rst_n        (autosa_core_rstn),
      .pwrbus_ram_pd(pwrbus_ram_pd),
      .in_vld       (push[g]),
      .in_rdy       (fifo_rdy[g]),
      .in_pd        (push_ent[g]),
      .out_vld      (fifo_vld[g]),
      .out_rdy      (pop),
      .out_pd       (head[g])
    );

    assign data_fifo_pd[g*LANE_W +: LANE_W] = data_fifo_vld ? head[g][LANE_W-1:0] : '0;
    assign data_fifo_mask[g]                = data_fifo_vld & head[g][LANE_W];
  end

endmodule

// File: tb/tb_sa_autosa_rubik_dr2drc_pack.sv
// Scoreboard bench: stimulus pushes expected beats from a lane-list model,
// an independent monitor pops and compares whenever a beat leaves the DUT.
module tb_sa_autosa_rubik_dr2drc_pack;
  localparam int LANES = 2;
  localparam int LW    = 32;
  localparam int DEPTH = 8;
  localparam int PW    = LANES * LW;
  localparam int RW    = LANES * (LW + 1);

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [31:0]      pwrbus_ram_pd = '0;
  logic             cfg_pack_en = 1'b0;
  logic             cfg_flush = 1'b0;
  logic             flush_done;
  logic             rd_rsp_vld = 1'b0;
  logic             rd_rsp_rdy;
  logic [RW-1:0]    rd_rsp_pd = '0;
  logic             data_fifo_vld;
  logic             data_fifo_rdy = 1'b1;
  logic [PW-1:0]    data_fifo_pd;
  logic [LANES-1:0] data_fifo_mask;
  logic             rd_cdt_lat_fifo_pop;

  sa_autosa_rubik_dr2drc_pack #(.LANES(LANES), .LANE_W(LW), .DEPTH(DEPTH)) dut (
    .autosa_core_clk    (clk),
    .autosa_core_rstn   (rstn),
    .pwrbus_ram_pd      (pwrbus_ram_pd),
    .cfg_pack_en        (cfg_pack_en),
    .cfg_flush          (cfg_flush),
    .flush_done         (flush_done),
    .rd_rsp_vld         (rd_rsp_vld),
    .rd_rsp_rdy         (rd_rsp_rdy),
    .rd_rsp_pd          (rd_rsp_pd),
    .data_fifo_vld      (data_fifo_vld),
    .data_fifo_rdy      (data_fifo_rdy),
    .data_fifo_pd       (data_fifo_pd),
    .data_fifo_mask     (data_fifo_mask),
    .rd_cdt_lat_fifo_pop(rd_cdt_lat_fifo_pop)
  );

  always #5 clk = ~clk;

  logic [PW-1:0]    exp_pd_q [$];
  logic [LANES-1:0] exp_mk_q [$];
  logic [LW-1:0]    pend [$];
  bit               mpack = 1'b0;
  int               nvec = 0, nfail = 0, npop = 0, ncdt = 0;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  function automatic void emit(input logic [LANES-1:0] m, input logic [PW-1:0] d);
    exp_mk_q.push_back(m);
    exp_pd_q.push_back(d);
  endfunction

  // Bypass: beat as-is with invalid lanes zeroed. Pack: valid lanes join one
  // ordered list that is cut into dense beats of LANES entries.
  function automatic void model_acc(input logic [LANES-1:0] m, input logic [PW-1:0] d);
    logic [PW-1:0] o;
    o = '0;
    if (!mpack) begin
      for (int i = 0; i < LANES; i++) if (m[i]) o[i*LW +: LW] = d[i*LW +: LW];
      emit(m, o);
    end else begin
      for (int i = 0; i < LANES; i++) if (m[i]) pend.push_back(d[i*LW +: LW]);
      while (pend.size() >= LANES) begin
        o = '0;
        for (int i = 0; i < LANES; i++) o[i*LW +: LW] = pend.pop_front();
        emit('1, o);
      end
      if (!cfg_pack_en && pend.size() == 0) mpack = 1'b0;
    end
  endfunction

  function automatic void model_flush();
    logic [PW-1:0]    o;
    logic [LANES-1:0] mk;
    int               n;
    o  = '0;
    mk = '0;
    n  = pend.size();
    if (n > 0) begin
      for (int i = 0; i < n; i++) begin
        o[i*LW +: LW] = pend.pop_front();
        mk[i] = 1'b1;
      end
      emit(mk, o);
    end
  endfunction

  function automatic logic [PW-1:0] rnd_pd();
    logic [PW-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*LW +: LW] = $urandom;
    return d;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [LANES-1:0] m, input logic [PW-1:0] d);
    int t;
    t = 0;
    rd_rsp_vld = 1'b1;
    rd_rsp_pd  = {m, d};
    forever begin
      @(negedge clk);
      if (rd_rsp_rdy) begin
        model_acc(m, d);
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      t++;
      if (t > 300) begin
        nvec++;
        nfail++;
        $display("FAIL send_timeout: rd_rsp_rdy stayed 0 for %0d cycles, expected 1", t);
        break;
      end
    end
    rd_rsp_vld = 1'b0;
  endtask

  task automatic set_pack(input bit v);
    cfg_pack_en = v;
    idle(2);
    if (v) mpack = 1'b1;
    else if (pend.size() == 0) mpack = 1'b0;
  endtask

  task automatic do_flush();
    bit got;
    got = 1'b0;
    cfg_flush = 1'b1;
    @(posedge clk);
    #1;
    cfg_flush = 1'b0;
    model_flush();
    mpack = cfg_pack_en;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (flush_done) got = 1'b1;
    end
    chk("flush_done_pulse", PW'(got), PW'(1));
  endtask

  task automatic drain();
    data_fifo_rdy = 1'b1;
    for (int t = 0; t < 400; t++) begin
      @(posedge clk);
      #1;
      if (exp_pd_q.size() == 0 && !data_fifo_vld) break;
    end
    chk("drain_queue", PW'(exp_pd_q.size()), PW'(0));
    chk("drain_vld", PW'(data_fifo_vld), PW'(0));
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (rd_cdt_lat_fifo_pop) ncdt++;
      if (data_fifo_vld && data_fifo_rdy) begin
        npop++;
        if (exp_pd_q.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL unexpected_beat: got pd=%h mask=%b, expected no beat", data_fifo_pd, data_fifo_mask);
        end else begin
          chk("beat_pd", data_fifo_pd, exp_pd_q.pop_front());
          chk("beat_mask", PW'(data_fifo_mask), PW'(exp_mk_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [LW-1:0] x, y, z, p;
    int            cnt;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", PW'(rd_rsp_rdy), PW'(0));
    chk("rst_vld", PW'(data_fifo_vld), PW'(0));
    chk("rst_pd", data_fifo_pd, PW'(0));
    chk("rst_mask", PW'(data_fifo_mask), PW'(0));
    chk("rst_flush_done", PW'(flush_done), PW'(0));
    chk("rst_pop", PW'(rd_cdt_lat_fifo_pop), PW'(0));
    rstn = 1'b1;
    idle(2);
    chk("post_rst_rdy", PW'(rd_rsp_rdy), PW'(1));

    // Bypass: lane 1 masked off must come out zero.
    send(2'b01, {32'hAAAA_0001, 32'hBBBB_0002});
    drain();

    // Pack: X,Y form one dense beat; Z is padded out by flush.
    x = $urandom; y = $urandom; z = $urandom;
    set_pack(1'b1);
    send(2'b01, {32'hDEAD_0000, x});
    send(2'b01, {32'hDEAD_0001, y});
    send(2'b10, {z, 32'hDEAD_0002});
    drain();
    do_flush();
    drain();

    // Backpressure in bypass: exactly DEPTH accepts, then stall.
    set_pack(1'b0);
    data_fifo_rdy = 1'b0;
    cnt = 0;
    for (int i = 0; i < 2*DEPTH + 4; i++) begin
      logic [LANES-1:0] m;
      logic [PW-1:0]    d;
      m = LANES'($urandom);
      d = rnd_pd();
      rd_rsp_vld = 1'b1;
      rd_rsp_pd  = {m, d};
      @(negedge clk);
      if (rd_rsp_rdy) begin
        model_acc(m, d);
        cnt++;
      end
      @(posedge clk);
      #1;
    end
    rd_rsp_vld = 1'b0;
    chk("bp_accepts", PW'(cnt), PW'(DEPTH));
    chk("bp_rdy_low", PW'(rd_rsp_rdy), PW'(0));
    drain();

    // Pack with rotor=1 and pack disabled: must hold PACK until flushed.
    p = $urandom;
    set_pack(1'b1);
    send(2'b01, {32'h0BAD_0BAD, p});
    set_pack(1'b0);
    idle(3);
    chk("hold_no_beat", PW'(data_fifo_vld), PW'(0));
    do_flush();
    idle(2);
    send(2'b10, {32'h5555_AAAA, 32'h1234_5678});
    send(2'b11, rnd_pd());
    drain();

    // Bypass at full-1 occupancy with random sink stalls.
    data_fifo_rdy = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) send(LANES'($urandom), rnd_pd());
    fork
      begin
        repeat (140) begin
          @(posedge clk);
          #1;
          data_fifo_rdy = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int i = 0; i < 100; i++) send(LANES'($urandom), rnd_pd());
      end
    join
    drain();

    // Random pack traffic with stalls.
    set_pack(1'b1);
    fork
      begin
        repeat (120) begin
          @(posedge clk);
          #1;
          data_fifo_rdy = ($urandom_range(0, 2) != 0);
        end
      end
      begin
        for (int i = 0; i < 60; i++) send(LANES'($urandom), rnd_pd());
      end
    join
    drain();
    do_flush();
    drain();

    // Reset mid-stream with a partial packed beat and a stored full beat.
    data_fifo_rdy = 1'b0;
    send(2'b11, rnd_pd());
    send(2'b01, rnd_pd());
    rstn = 1'b0;
    #1;
    chk("mid_rst_vld", PW'(data_fifo_vld), PW'(0));
    chk("mid_rst_rdy", PW'(rd_rsp_rdy), PW'(0));
    exp_pd_q.delete();
    exp_mk_q.delete();
    pend.delete();
    cfg_pack_en = 1'b0;
    mpack = 1'b0;
    idle(2);
    rstn = 1'b1;
    idle(2);
    chk("post_rst2_vld", PW'(data_fifo_vld), PW'(0));
    chk("post_rst2_rdy", PW'(rd_rsp_rdy), PW'(1));
    data_fifo_rdy = 1'b1;
    set_pack(1'b1);
    send(2'b11, {32'hCCCC_0003, 32'hDDDD_0004});
    send(2'b10, {32'hEEEE_0005, 32'h0});
    drain();
    do_flush();
    drain();

    chk("credit_vs_pops", PW'(ncdt), PW'(npop));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
